// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module   : instr_fetch_pkg
// Brief    : Shared types and encodings for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

    typedef enum logic [1:0] {
        J_ABS  = 2'b00,
        J_REL  = 2'b01,
        J_CALL = 2'b10,
        J_RET  = 2'b11
    } jmode_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        VALID = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_ram.sv
// ============================================================================
// Module   : fetch_ram
// Brief    : Single-clock program RAM, one sync read port, one write port,
//            read-first on address collision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ram #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem_q [0:(1<<ASIZE)-1];

    // Read samples the array before this edge's write lands, giving read-first.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata <= mem_q[raddr];
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : PC, loadable program RAM and call/return stack with a valid/
//            advance handshake. Optional macro INSTR_FETCH_PERF_EN adds
//            retired/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH_INSTR = 8,
    parameter int WIDTH_ADDR  = 8,
    parameter int WIDTH_JDATA = 24,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   prog_we,
    input  logic [WIDTH_ADDR-1:0]  prog_addr,
    input  logic [WIDTH_INSTR-1:0] prog_data,
    input  logic                   next_instr,
    input  logic                   jump,
    input  logic [1:0]             jmode,
    input  logic [WIDTH_JDATA-1:0] jdata,
    output logic [WIDTH_INSTR-1:0] instr,
    output logic                   instr_valid,
    output logic [WIDTH_ADDR-1:0]  pc,
    output logic                   stack_err
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]            retired_cnt,
    output logic [15:0]            flush_cnt
`endif
);

    localparam logic [1:0] S_FILL  = 2'(FILL);
    localparam logic [1:0] S_VALID = 2'(VALID);
    localparam logic [1:0] S_FLUSH = 2'(FLUSH);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    logic [1:0]             state_q, state_d;
    logic [WIDTH_ADDR-1:0]  pc_q, pc_d;
    logic [SPW-1:0]         sp_q, sp_d;
    logic                   err_q, err_d;
    logic [WIDTH_ADDR-1:0]  stack_q [0:STACK_DEPTH-1];
    logic                   push, taken;
    logic [WIDTH_ADDR-1:0]  pc_inc, jtarget;
    logic [WIDTH_INSTR-1:0] rdata;
    logic                   unused_jdata;
    jmode_t                 mode;

    assign pc_inc       = pc_q + 1'b1;
    assign jtarget      = jdata[WIDTH_ADDR-1:0];
    assign mode         = jmode_t'(jmode);
    assign unused_jdata = ^jdata;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
        taken   = 1'b0;
        case (state_q)
            S_FILL, S_FLUSH: state_d = S_VALID;
            S_VALID: begin
                if (jump) begin
                    case (mode)
                        J_ABS: begin
                            taken = 1'b1;
                            pc_d  = jtarget;
                        end
                        J_REL: begin
                            taken = 1'b1;
                            pc_d  = pc_q + jtarget;
                        end
                        J_CALL: begin
                            if (sp_q == SP_FULL) begin
                                err_d = 1'b1;
                                pc_d  = pc_inc;
                            end else begin
                                taken = 1'b1;
                                push  = 1'b1;
                                sp_d  = sp_q + 1'b1;
                                pc_d  = jtarget;
                            end
                        end
                        default: begin
                            if (sp_q == '0) begin
                                err_d = 1'b1;
                                pc_d  = pc_inc;
                            end else begin
                                taken = 1'b1;
                                sp_d  = sp_q - 1'b1;
                                pc_d  = stack_q[IW'(sp_q - 1'b1)];
                            end
                        end
                    endcase
                end else if (next_instr) begin
                    pc_d = pc_inc;
                end
                if (taken) begin
                    state_d = S_FLUSH;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FILL;
            pc_q    <= WIDTH_ADDR'(RESET_ADDR);
            sp_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            if (push) begin
                stack_q[IW'(sp_q)] <= pc_inc;
            end
        end
    end

    // Reading at pc_d lets a plain advance deliver the next word with no bubble.
    fetch_ram #(
        .DSIZE (WIDTH_INSTR),
        .ASIZE (WIDTH_ADDR)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_d),
        .rdata (rdata)
    );

    assign instr_valid = (state_q == S_VALID);
    assign instr       = instr_valid ? rdata : '0;
    assign pc          = pc_q;
    assign stack_err   = err_q;

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retired_cnt <= '0;
            flush_cnt   <= '0;
        end else begin
            if (instr_valid && (next_instr || taken) && (retired_cnt != '1)) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
            if (taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed self-checking bench for instr_fetch (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [7:0]  prog_data;
    logic        next_instr;
    logic        jump;
    logic [1:0]  jmode;
    logic [23:0] jdata;
    logic [7:0]  instr;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        stack_err;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch #(
        .WIDTH_INSTR (8),
        .WIDTH_ADDR  (8),
        .WIDTH_JDATA (24),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .next_instr  (next_instr),
        .jump        (jump),
        .jmode       (jmode),
        .jdata       (jdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] prog_word(input logic [7:0] a);
        return (a == 8'h40) ? 8'hAA : 8'(a + 8'h10);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [7:0] exp_pc);
        check_eq({tag, " valid"}, 32'(instr_valid), 32'd1);
        check_eq({tag, " pc"},    32'(pc),          32'(exp_pc));
        check_eq({tag, " instr"}, 32'(instr),       32'(prog_word(exp_pc)));
    endtask

    // Issues a transfer, checks the bubble, and lands on the target.
    task automatic xfer(input string tag, input logic [1:0] m, input logic [23:0] d,
                        input logic [7:0] exp_pc);
        jump  = 1'b1;
        jmode = m;
        jdata = d;
        step();
        jump = 1'b0;
        check_eq({tag, " bubble"}, 32'(instr_valid), 32'd0);
        check_eq({tag, " tgt pc"}, 32'(pc), 32'(exp_pc));
        step();
        check_fetch(tag, exp_pc);
    endtask

    initial begin
        rstn       = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        next_instr = 1'b0;
        jump       = 1'b0;
        jmode      = 2'b00;
        jdata      = '0;

        for (int i = 0; i < 256; i++) begin
            step();
            prog_we   = 1'b1;
            prog_addr = 8'(i);
            prog_data = prog_word(8'(i));
        end
        step();
        prog_we = 1'b0;
        check_eq("rst valid", 32'(instr_valid), 32'd0);
        check_eq("rst instr", 32'(instr),       32'd0);
        check_eq("rst pc",    32'(pc),          32'd0);
        check_eq("rst err",   32'(stack_err),   32'd0);

        rstn       = 1'b1;
        next_instr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_fetch("seq", 8'(i));
        end

        // At pc=5: relative -3 with next_instr also high
        xfer("rel", 2'b01, 24'hFFFFFD, 8'h02);
        step();
        check_fetch("after rel", 8'h03);

        next_instr = 1'b0;
        xfer("call", 2'b10, 24'h000040, 8'h40);
        xfer("ret", 2'b11, 24'h0, 8'h04);
        check_eq("err after ret", 32'(stack_err), 32'd0);

        xfer("abs10", 2'b00, 24'h000010, 8'h10);
        next_instr = 1'b1;
        xfer("jump wins", 2'b00, 24'hABCD80, 8'h80);
        next_instr = 1'b0;

        xfer("abs ff", 2'b00, 24'h0000FF, 8'hFF);
        next_instr = 1'b1;
        step();
        check_fetch("wrap", 8'h00);
        next_instr = 1'b0;

        xfer("call1", 2'b10, 24'h20, 8'h20);
        xfer("call2", 2'b10, 24'h30, 8'h30);
        xfer("call3", 2'b10, 24'h50, 8'h50);
        xfer("call4", 2'b10, 24'h60, 8'h60);
        check_eq("err before full", 32'(stack_err), 32'd0);
        jump  = 1'b1;
        jmode = 2'b10;
        jdata = 24'h70;
        step();
        jump = 1'b0;
        check_fetch("call5 not taken", 8'h61);
        check_eq("err full", 32'(stack_err), 32'd1);

        xfer("ret4", 2'b11, 24'h0, 8'h51);
        xfer("ret3", 2'b11, 24'h0, 8'h31);
        xfer("ret2", 2'b11, 24'h0, 8'h21);
        xfer("ret1", 2'b11, 24'h0, 8'h01);

        // Reset in the middle of a flush
        jump  = 1'b1;
        jmode = 2'b00;
        jdata = 24'h50;
        step();
        jump = 1'b0;
        check_eq("pre-rst flush", 32'(instr_valid), 32'd0);
        rstn = 1'b0;
        #1;
        check_eq("mid rst valid", 32'(instr_valid), 32'd0);
        check_eq("mid rst instr", 32'(instr),       32'd0);
        check_eq("mid rst pc",    32'(pc),          32'd0);
        check_eq("mid rst err",   32'(stack_err),   32'd0);
        step();
        rstn = 1'b1;
        step();
        check_fetch("refetch", 8'h00);

        jump  = 1'b1;
        jmode = 2'b11;
        step();
        jump = 1'b0;
        check_fetch("ret empty", 8'h01);
        check_eq("err empty", 32'(stack_err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
